// File: rtl/crop_frame_collector.sv
// Receive-side frame buffer for the crop filter. It collects one cropped frame
// in raster order, then holds that frame for a reader until the reader acks it.
module crop_frame_collector #(
  parameter int OUT_ROWS = 20,
  parameter int OUT_COLS = 20,
  parameter int PIX_W    = 12,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              frame_valid,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic [15:0]       frame_count
);

  localparam int unsigned DEPTH = OUT_ROWS * OUT_COLS;
  localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int COL_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_FILL,
    S_FULL
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [ADDR_W-1:0] wr_addr;
  logic              xfer, last_pix;

  logic [PIX_W-1:0]  mem [0:(2**ADDR_W)-1];

  // The state register alone gates transfers, so in_valid reaches no output combinationally.
  assign xfer     = (state_q == S_FILL) && in_valid;
  assign last_pix = xfer && (wr_row == LAST_ROW) && (wr_col == LAST_COL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_FILL;
      S_FILL:  if (last_pix) state_d = S_FULL;
      S_FULL:  if (frame_ack) state_d = S_FILL;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      in_ready    <= 1'b0;
      frame_valid <= 1'b0;
      wr_row      <= '0;
      wr_col      <= '0;
      wr_addr     <= '0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      in_ready    <= (state_d == S_FILL);
      frame_valid <= (state_d == S_FULL);
      if ((state_q == S_INIT) || ((state_q == S_FULL) && frame_ack)) begin
        wr_row  <= '0;
        wr_col  <= '0;
        wr_addr <= '0;
      end else if (last_pix) begin
        // Counters rewind on the last pixel instead of stepping past their terminal values.
        wr_row      <= '0;
        wr_col      <= '0;
        wr_addr     <= '0;
        frame_count <= frame_count + 16'd1;
      end else if (xfer) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        if (wr_col == LAST_COL) begin
          wr_col <= '0;
          wr_row <= wr_row + ROW_W'(1);
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[wr_addr] <= pixel_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rd_data <= '0;
    else if (32'(rd_addr) < DEPTH)
      rd_data <= mem[rd_addr];
    else
      rd_data <= '0;
  end

endmodule
